// File: rtl/noc_mem_chan_pkg.sv
// Shared types and flit helpers for the NoC memory-channel splitter.
package noc_mem_chan_pkg;

  // Widest flit the helpers handle; callers zero-extend into this width.
  localparam int MAX_W = 256;

  typedef enum logic [2:0] {
    REQ_IDLE, REQ_ADDR, REQ_SEND_HDR, REQ_SEND_ADDR, REQ_PASS
  } req_state_e;

  typedef enum logic {RSP_IDLE, RSP_LOCK} rsp_state_e;

  function automatic logic [MAX_W-1:0] get_len(input logic [MAX_W-1:0] flit,
                                               input int lsb, input int w);
    return (flit >> lsb) & ~({MAX_W{1'b1}} << w);
  endfunction

  // Squeeze the channel-select bits out of the address field, leaving bits
  // above the address untouched.
  function automatic logic [MAX_W-1:0] strip_addr(input logic [MAX_W-1:0] flit,
                                                  input int addr_w, input int lsb,
                                                  input int sel_w);
    logic [MAX_W-1:0] am, lm, a;
    am = ~({MAX_W{1'b1}} << addr_w);
    lm = ~({MAX_W{1'b1}} << lsb);
    a  = flit & am;
    return (flit & ~am) | ((a >> (lsb + sel_w)) << lsb) | (a & lm);
  endfunction

endpackage

// File: rtl/noc_rr_pkt_arbiter.sv
// Round-robin response merger that holds a grant for a whole packet.
module noc_rr_pkt_arbiter
  import noc_mem_chan_pkg::*;
#(
  parameter int NUM_CHAN = 2,
  parameter int DATA_W   = 64,
  parameter int LEN_LSB  = 22,
  parameter int LEN_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CHAN-1:0]        in_val,
  input  logic [NUM_CHAN*DATA_W-1:0] in_data,
  output logic [NUM_CHAN-1:0]        in_rdy,
  output logic                       out_val,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_rdy
);

  localparam int SEL_W = $clog2(NUM_CHAN);

  rsp_state_e                      st;
  logic [SEL_W-1:0]                g, rr_ptr, pick;
  logic                            found, first, fire, last;
  logic [LEN_W-1:0]                rem, hdr_len;
  logic [NUM_CHAN-1:0][DATA_W-1:0] data_a;

  assign data_a   = in_data;
  assign out_data = data_a[g];
  assign hdr_len  = LEN_W'(get_len(MAX_W'(out_data), LEN_LSB, LEN_W));
  assign fire     = out_val && out_rdy;
  assign last     = first ? (hdr_len == '0) : (rem == LEN_W'(1));

  // Descending scan so the requester closest to rr_ptr is the last writer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (in_val[rr_ptr + SEL_W'(i)]) begin
        found = 1'b1;
        pick  = rr_ptr + SEL_W'(i);
      end
    end
  end

  always_comb begin
    out_val = 1'b0;
    in_rdy  = '0;
    if (st == RSP_LOCK) begin
      out_val   = in_val[g];
      in_rdy[g] = out_rdy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= RSP_IDLE;
      g      <= '0;
      rr_ptr <= '0;
      rem    <= '0;
      first  <= 1'b0;
    end else begin
      unique case (st)
        RSP_IDLE: if (found) begin
          g     <= pick;
          first <= 1'b1;
          st    <= RSP_LOCK;
        end
        RSP_LOCK: if (fire) begin
          if (first) begin
            rem   <= hdr_len;
            first <= 1'b0;
          end else begin
            rem <= rem - LEN_W'(1);
          end
          if (last) begin
            rr_ptr <= g + SEL_W'(1);
            st     <= RSP_IDLE;
          end
        end
        default: st <= RSP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/noc_mem_chan_splitter.sv
// Routes NoC request packets to NUM_CHAN memory channels by address interleave
// and merges their responses. NOC_CHAN_ADDR_STRIP_EN compacts forwarded addresses.
module noc_mem_chan_splitter
  import noc_mem_chan_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int NUM_CHAN  = 2,
  parameter int LEN_LSB   = 22,
  parameter int LEN_W     = 8,
  parameter int ADDR_W    = 40,
  parameter int INTLV_LSB = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in_val,
  input  logic [DATA_W-1:0]          req_in_data,
  output logic                       req_in_rdy,
  output logic [NUM_CHAN-1:0]        req_out_val,
  output logic [NUM_CHAN*DATA_W-1:0] req_out_data,
  input  logic [NUM_CHAN-1:0]        req_out_rdy,
  input  logic [NUM_CHAN-1:0]        rsp_in_val,
  input  logic [NUM_CHAN*DATA_W-1:0] rsp_in_data,
  output logic [NUM_CHAN-1:0]        rsp_in_rdy,
  output logic                       rsp_out_val,
  output logic [DATA_W-1:0]          rsp_out_data,
  input  logic                       rsp_out_rdy
);

  localparam int SEL_W = $clog2(NUM_CHAN);
`ifdef NOC_CHAN_ADDR_STRIP_EN
  localparam bit STRIP_EN = 1'b1;
`else
  localparam bit STRIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SEL_W-1:0]  chan;
  } req_ctx_t;

  req_state_e                      req_st;
  req_ctx_t                        ctx;
  logic [LEN_W-1:0]                rem, in_len;
  logic [DATA_W-1:0]               out_flit, addr_fwd;
  logic                            out_val, out_rdy;
  logic [NUM_CHAN-1:0][DATA_W-1:0] req_data_a;

  assign in_len   = LEN_W'(get_len(MAX_W'(req_in_data), LEN_LSB, LEN_W));
  assign addr_fwd = STRIP_EN ? DATA_W'(strip_addr(MAX_W'(req_in_data), ADDR_W, INTLV_LSB, SEL_W))
                             : req_in_data;
  assign out_rdy  = req_out_rdy[ctx.chan];

  always_comb begin
    out_val    = 1'b0;
    out_flit   = req_in_data;
    req_in_rdy = 1'b0;
    unique case (req_st)
      REQ_IDLE, REQ_ADDR: req_in_rdy = !rst;
      REQ_SEND_HDR: begin
        out_val  = 1'b1;
        out_flit = ctx.hdr;
      end
      REQ_SEND_ADDR: begin
        out_val  = 1'b1;
        out_flit = ctx.addr;
      end
      REQ_PASS: begin
        out_val    = req_in_val;
        req_in_rdy = out_rdy;
      end
      default: ;
    endcase
  end

  // Every channel sees the same flit bus; only the selected one sees valid.
  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    assign req_out_val[c] = out_val && (ctx.chan == SEL_W'(c));
    assign req_data_a[c]  = out_flit;
  end
  assign req_out_data = req_data_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_st <= REQ_IDLE;
      ctx    <= '0;
      rem    <= '0;
    end else begin
      unique case (req_st)
        REQ_IDLE: if (req_in_val) begin
          ctx.hdr <= req_in_data;
          ctx.len <= in_len;
          if (in_len == '0) begin
            ctx.chan <= '0;
            req_st   <= REQ_SEND_HDR;
          end else begin
            req_st <= REQ_ADDR;
          end
        end
        REQ_ADDR: if (req_in_val) begin
          ctx.addr <= addr_fwd;
          ctx.chan <= req_in_data[INTLV_LSB +: SEL_W];
          req_st   <= REQ_SEND_HDR;
        end
        REQ_SEND_HDR: if (out_rdy)
          req_st <= (ctx.len == '0) ? REQ_IDLE : REQ_SEND_ADDR;
        REQ_SEND_ADDR: if (out_rdy) begin
          rem    <= ctx.len - LEN_W'(1);
          req_st <= (ctx.len == LEN_W'(1)) ? REQ_IDLE : REQ_PASS;
        end
        REQ_PASS: if (req_in_val && out_rdy) begin
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) req_st <= REQ_IDLE;
        end
        default: req_st <= REQ_IDLE;
      endcase
    end
  end

  noc_rr_pkt_arbiter #(
    .NUM_CHAN(NUM_CHAN),
    .DATA_W  (DATA_W),
    .LEN_LSB (LEN_LSB),
    .LEN_W   (LEN_W)
  ) u_rsp_arb (
    .clk     (clk),
    .rst     (rst),
    .in_val  (rsp_in_val),
    .in_data (rsp_in_data),
    .in_rdy  (rsp_in_rdy),
    .out_val (rsp_out_val),
    .out_data(rsp_out_data),
    .out_rdy (rsp_out_rdy)
  );

endmodule

// File: tb/tb_noc_mem_chan_splitter.sv
// Directed bench for noc_mem_chan_splitter, NUM_CHAN=2, INTLV_LSB=6.
module tb_noc_mem_chan_splitter;

  logic         clk, rst;
  logic         req_in_val, req_in_rdy;
  logic [63:0]  req_in_data;
  logic [1:0]   req_out_val, req_out_rdy;
  logic [127:0] req_out_data;
  logic [1:0]   rsp_in_val, rsp_in_rdy;
  logic [127:0] rsp_in_data;
  logic         rsp_out_val, rsp_out_rdy;
  logic [63:0]  rsp_out_data;
  logic [63:0]  ch0, ch1;
  int           checks = 0, failures = 0;

  localparam logic [63:0] H1 = 64'hA100_0000_0080_0000, A1 = 64'h40, D1 = 64'hD1D1_0000_0000_0001;
  localparam logic [63:0] H2 = 64'hA200_0000_0040_0000, A2 = 64'h80;
  localparam logic [63:0] H3 = 64'hA300_0000_0000_0000, X3 = 64'hEEEE;
  localparam logic [63:0] R0H = 64'hB000_0000_0080_0000, R0A = 64'hB0A, R0B = 64'hB0B;
  localparam logic [63:0] R1H = 64'hB100_0000_0080_0000, R1A = 64'hB1A, R1B = 64'hB1B;
  localparam logic [63:0] Z0 = 64'hC000_0000_0000_0000, Z1 = 64'hC100_0000_0000_0000;
  localparam logic [63:0] H5 = 64'hA500_0000_00C0_0000, A5 = 64'h40, D5 = 64'hD5;
  localparam logic [63:0] H6 = 64'hA600_0000_0040_0000, A6 = 64'h80;
  localparam logic [63:0] H7 = 64'hA700_0000_0040_0000, A7 = 64'hAB00_0000_0000_01C5;
`ifdef NOC_CHAN_ADDR_STRIP_EN
  localparam logic [63:0] A7X = 64'hAB00_0000_0000_00C5;
`else
  localparam logic [63:0] A7X = 64'hAB00_0000_0000_01C5;
`endif

  noc_mem_chan_splitter #(
    .DATA_W(64), .NUM_CHAN(2), .LEN_LSB(22), .LEN_W(8), .ADDR_W(40), .INTLV_LSB(6)
  ) dut (
    .clk(clk), .rst(rst),
    .req_in_val(req_in_val), .req_in_data(req_in_data), .req_in_rdy(req_in_rdy),
    .req_out_val(req_out_val), .req_out_data(req_out_data), .req_out_rdy(req_out_rdy),
    .rsp_in_val(rsp_in_val), .rsp_in_data(rsp_in_data), .rsp_in_rdy(rsp_in_rdy),
    .rsp_out_val(rsp_out_val), .rsp_out_data(rsp_out_data), .rsp_out_rdy(rsp_out_rdy)
  );

  assign ch0 = req_out_data[63:0];
  assign ch1 = req_out_data[127:64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_in_val = 1'b0; req_in_data = '0; req_out_rdy = 2'b11;
    rsp_in_val = '0; rsp_in_data = '0; rsp_out_rdy = 1'b1;
    mid();
    chk("rst_req_val", 64'(req_out_val), 64'd0);
    chk("rst_rsp_val", 64'(rsp_out_val), 64'd0);
    chk("rst_rsp_rdy", 64'(rsp_in_rdy), 64'd0);
    tick(); rst = 1'b0;
    mid(); chk("rdy_after_rst", 64'(req_in_rdy), 64'd1);

    // len=2 packet to channel 1
    tick(); req_in_val = 1'b1; req_in_data = H1;
    mid(); chk("t1_hdr_rdy", 64'(req_in_rdy), 64'd1);
    tick(); req_in_data = A1;
    mid(); chk("t1_addr_rdy", 64'(req_in_rdy), 64'd1);
    chk("t1_addr_noval", 64'(req_out_val), 64'd0);
    tick(); req_in_data = D1;
    mid(); chk("t1_hdr_val", 64'(req_out_val), 64'd2);
    chk("t1_hdr_data", ch1, H1);
    chk("t1_hdr_inrdy", 64'(req_in_rdy), 64'd0);
    tick();
    mid(); chk("t1_addr_val", 64'(req_out_val), 64'd2);
    chk("t1_addr_data", ch1, A1);
    tick();
    mid(); chk("t1_pass_val", 64'(req_out_val), 64'd2);
    chk("t1_pass_data", ch1, D1);
    chk("t1_pass_rdy", 64'(req_in_rdy), 64'd1);
    tick(); req_in_val = 1'b0;
    mid(); chk("t1_end_val", 64'(req_out_val), 64'd0);
    chk("t1_end_rdy", 64'(req_in_rdy), 64'd1);

    // len=1 to channel 0 under back-pressure
    req_out_rdy = 2'b10; req_in_val = 1'b1; req_in_data = H2;
    tick(); req_in_data = A2;
    tick(); req_in_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("t2_hold_val", 64'(req_out_val), 64'd1);
      chk("t2_hold_data", ch0, H2);
      chk("t2_hold_rdy", 64'(req_in_rdy), 64'd0);
      tick();
    end
    req_out_rdy = 2'b11;
    mid(); chk("t2_hdr_data", ch0, H2);
    tick();
    mid(); chk("t2_addr_val", 64'(req_out_val), 64'd1);
    chk("t2_addr_data", ch0, A2);
    tick();
    mid(); chk("t2_next_rdy", 64'(req_in_rdy), 64'd1);
    chk("t2_idle_val", 64'(req_out_val), 64'd0);

    // len=0 header, no address flit consumed
    req_in_val = 1'b1; req_in_data = H3;
    tick(); req_in_data = X3;
    mid(); chk("t3_hdr_val", 64'(req_out_val), 64'd1);
    chk("t3_hdr_data", ch0, H3);
    chk("t3_hdr_inrdy", 64'(req_in_rdy), 64'd0);
    tick();
    mid(); chk("t3_idle_val", 64'(req_out_val), 64'd0);
    chk("t3_idle_rdy", 64'(req_in_rdy), 64'd1);
    req_in_val = 1'b0;

    // simultaneous 3-flit responses
    rsp_in_val = 2'b11; rsp_in_data = {R1H, R0H};
    chk("t4_idle_val", 64'(rsp_out_val), 64'd0);
    tick();
    mid(); chk("t4_g0_val", 64'(rsp_out_val), 64'd1);
    chk("t4_g0_hdr", rsp_out_data, R0H);
    chk("t4_g0_rdy", 64'(rsp_in_rdy), 64'd1);
    tick(); rsp_in_data[63:0] = R0A;
    mid(); chk("t4_g0_d1", rsp_out_data, R0A);
    chk("t4_g0_rdy1", 64'(rsp_in_rdy), 64'd1);
    tick(); rsp_in_data[63:0] = R0B;
    mid(); chk("t4_g0_d2", rsp_out_data, R0B);
    tick(); rsp_in_val = 2'b10;
    mid(); chk("t4_bubble_val", 64'(rsp_out_val), 64'd0);
    chk("t4_bubble_rdy", 64'(rsp_in_rdy), 64'd0);
    tick();
    mid(); chk("t4_g1_hdr", rsp_out_data, R1H);
    chk("t4_g1_rdy", 64'(rsp_in_rdy), 64'd2);
    tick(); rsp_in_data[127:64] = R1A;
    mid(); chk("t4_g1_d1", rsp_out_data, R1A);
    tick(); rsp_in_data[127:64] = R1B;
    mid(); chk("t4_g1_d2", rsp_out_data, R1B);
    tick(); rsp_in_val = 2'b11; rsp_in_data = {Z1, Z0};
    mid(); chk("t4_bubble2", 64'(rsp_out_val), 64'd0);
    tick();
    mid(); chk("t4_rr0_rdy", 64'(rsp_in_rdy), 64'd1);
    chk("t4_rr0_data", rsp_out_data, Z0);
    tick(); rsp_in_val = 2'b10;
    mid(); chk("t4_len0_end", 64'(rsp_out_val), 64'd0);
    tick();
    mid(); chk("t4_rr1_rdy", 64'(rsp_in_rdy), 64'd2);
    chk("t4_rr1_data", rsp_out_data, Z1);
    tick(); rsp_in_val = 2'b00;

    // reset in PASS with rem=2
    req_in_val = 1'b1; req_in_data = H5;
    tick(); req_in_data = A5;
    tick(); req_in_data = D5;
    tick();
    tick();
    mid(); chk("t5_pass_val", 64'(req_out_val), 64'd2);
    chk("t5_pass_data", ch1, D5);
    rst = 1'b1;
    #1 chk("t5_rst_val", 64'(req_out_val), 64'd0);
    tick(); req_in_val = 1'b0; rst = 1'b0;
    mid(); chk("t5_post_val", 64'(req_out_val), 64'd0);
    chk("t5_post_rsp", 64'(rsp_out_val), 64'd0);
    chk("t5_post_rdy", 64'(req_in_rdy), 64'd1);
    req_in_val = 1'b1; req_in_data = H6;
    tick(); req_in_data = A6;
    tick(); req_in_val = 1'b0;
    mid(); chk("t5_new_val", 64'(req_out_val), 64'd1);
    chk("t5_new_hdr", ch0, H6);
    tick();
    mid(); chk("t5_new_addr", ch0, A6);

    // address strip option
    tick(); req_in_val = 1'b1; req_in_data = H7;
    tick(); req_in_data = A7;
    tick(); req_in_val = 1'b0;
    mid(); chk("t6_hdr_val", 64'(req_out_val), 64'd2);
    chk("t6_hdr_data", ch1, H7);
    tick();
    mid(); chk("t6_addr_val", 64'(req_out_val), 64'd2);
    chk("t6_addr_data", ch1, A7X);
    tick();
    mid(); chk("t6_idle_val", 64'(req_out_val), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_mem_chan_splitter.md
Name: noc_mem_chan_splitter

Overview:
- Single-clock NoC-side distributor that sits between the chipset NoC/afifo and NUM_CHAN independent noc_axi4_bridge + memory-controller channels.
- Request packets are routed whole to one channel, chosen by address interleave bits in the address flit.
- Response packets from all channels are merged back onto one NoC stream by a packet-locked round-robin arbiter.
- Generalises the single-channel memory path to N channels with interleaving.

Parameters:
- DATA_W, 64, NoC flit width.
- NUM_CHAN, 2, number of memory channels; power of two, 2..8.
- SEL_W, $clog2(NUM_CHAN), channel-select width (derived).
- LEN_LSB, 22, LSB of the payload-length field in the header flit.
- LEN_W, 8, payload-length field width (flits following the header).
- ADDR_W, 40, address field width; address occupies flit1[ADDR_W-1:0].
- INTLV_LSB, 6, LSB of the channel-select bits in the address (64 B interleave).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_in_val  in  1  request flit valid from the NoC.
- req_in_data  in  DATA_W  request flit.
- req_in_rdy  out  1  request flit accept.
- req_out_val  out  NUM_CHAN  per-channel request valid.
- req_out_data  out  NUM_CHAN*DATA_W  per-channel flit; channel i at [i*DATA_W +: DATA_W].
- req_out_rdy  in  NUM_CHAN  per-channel ready.
- rsp_in_val  in  NUM_CHAN  per-channel response valid.
- rsp_in_data  in  NUM_CHAN*DATA_W  per-channel response flit.
- rsp_in_rdy  out  NUM_CHAN  per-channel response accept.
- rsp_out_val  out  1  merged response valid to the NoC.
- rsp_out_data  out  DATA_W  merged response flit.
- rsp_out_rdy  in  1  NoC ready.

Behaviour:
- Handshakes are val/rdy; a transfer occurs when both are high on a rising clk edge.
- Reset:
  - Both FSMs go to IDLE, the remaining-flit counters clear, and rr_ptr is 0.
  - All req_out_val, rsp_out_val and rsp_in_rdy outputs are 0.
  - req_in_rdy is 1 once rst deasserts.
  - Reset mid-packet discards the partial packet and emits no further flits.
- Request FSM:
  - IDLE: rdy=1. On accept, store the header in hdr_q and len = hdr[LEN_LSB +: LEN_W].
    - If len==0, set chan=0 and go to SEND_HDR.
    - Otherwise go to ADDR.
  - ADDR: rdy=1. On accept, store the flit in addr_q and set chan = flit[INTLV_LSB +: SEL_W]; go to SEND_HDR.
  - SEND_HDR: req_out_val[chan]=1 with hdr_q; req_in_rdy=0. On accept:
    - len==0 goes to IDLE.
    - Otherwise go to SEND_ADDR.
  - SEND_ADDR: emit addr_q. On accept, load rem = len-1.
    - rem==0 goes to IDLE.
    - Otherwise go to PASS.
  - PASS: combinational pass-through.
    - req_out_val[chan] = req_in_val, req_in_rdy = req_out_rdy[chan], data forwarded unchanged.
    - rem decrements on each transfer; the transfer taken with rem==1 returns the FSM to IDLE.
  - Non-selected channels always see val=0.
  - Latency: the header appears on the output the cycle after the address flit is accepted.
  - Minimum 4 cycles for a 2-flit packet.
- Response arbiter:
  - IDLE: scan rsp_in_val starting at rr_ptr, wrapping modulo NUM_CHAN, and register grant g; rsp_out_val=0.
  - LOCK: pass-through.
    - rsp_out_val = rsp_in_val[g], rsp_in_rdy[g] = rsp_out_rdy, other rsp_in_rdy = 0.
    - The first flit is the header; load rem from its length field.
    - The packet ends on the header transfer if len==0, otherwise on the transfer taken with rem==1.
    - At packet end set rr_ptr = g+1 mod NUM_CHAN and return to IDLE.
  - One-cycle bubble per response packet.
  - A grant is never switched mid-packet.
- The request and response paths are fully independent; simultaneous activity on both is legal.

Optional Feature:
- Macro: NOC_CHAN_ADDR_STRIP_EN.
- When defined, the forwarded address flit removes the select bits:
  - addr' = {zeros(SEL_W), addr[ADDR_W-1 : INTLV_LSB+SEL_W], addr[INTLV_LSB-1:0]}.
  - Flit bits above ADDR_W are unchanged.
  - Each channel therefore sees a compact, contiguous address space.
- When undefined, the address flit is forwarded unmodified.

Decomposition:
- Package noc_mem_chan_pkg:
  - req_state_e {IDLE, ADDR, SEND_HDR, SEND_ADDR, PASS} and rsp_state_e {IDLE, LOCK}.
  - Function get_len(flit).
  - Function strip_addr(flit).
- Sub-module noc_rr_pkt_arbiter: the response-side round-robin arbiter with packet lock, parametrised on NUM_CHAN, DATA_W, LEN_LSB and LEN_W.

Test Plan (NUM_CHAN=2, INTLV_LSB=6):
1. Request with len=2, addr=0x40, plus one data flit -> header, addr and data appear in order on channel 1 only; req_out_val[0] stays 0 throughout.
2. Request with addr=0x80, len=1, with req_out_rdy[0] held low 5 cycles -> header is held stable on channel 0 with req_in_rdy=0, then drains; next header is accepted the cycle after the address flit transfers.
3. len=0 header -> routed to channel 0 in SEND_HDR; FSM back in IDLE; no address flit is consumed.
4. Both channels present 3-flit responses simultaneously with rr_ptr=0 -> channel 0 packet contiguous, 1-cycle bubble, then channel 1 packet; rr_ptr ends at 0.
5. Assert rst during PASS with rem=2 -> all valids 0 the next cycle; a fresh packet then routes correctly.
6. NOC_CHAN_ADDR_STRIP_EN defined, addr=0x1C5 -> channel 1 receives address 0xC5; undefined -> receives 0x1C5.
